// File: rtl/riscv_dmem_ctrl.sv
// riscv_dmem_ctrl
// Word-organised data memory behind the LSU mem_* bus. A request is captured
// in IDLE, held for WAIT_STATES cycles, then completed in RESP with a
// single-cycle mem_ready_o pulse. Writes commit at the RESP clock edge under
// byte enables. Reads present the full 32-bit word during RESP, and
// mem_rd_o keeps that word afterwards.
//
// Optional feature macro: RISCV_DMEM_RANGE_CHECK_EN
//   defined   : mem_err_o exists. Out-of-window accesses complete with error,
//               the write is suppressed and the read data is zero.
//   undefined : no mem_err_o port. Addresses wrap modulo DEPTH words.
//
// State table:
//   state  | meaning
//   IDLE   | accepting; a request is captured on this edge
//   WAIT   | counting down the wait states; inputs ignored
//   RESP   | mem_ready_o pulse; write commits at the end of this cycle
//
// Ports:
//   clk_i        in   clock, rising edge
//   rst_i        in   synchronous active-high reset
//   mem_req_i    in   access request, held until mem_ready_o
//   mem_we_i     in   1 = write, 0 = read
//   mem_be_i     in   [3:0] write byte-lane enables
//   mem_addr_i   in   [31:0] byte address (bits 1:0 ignored)
//   mem_wd_i     in   [31:0] write data
//   mem_rd_o     out  [31:0] read data, valid with mem_ready_o
//   mem_ready_o  out  one-cycle completion pulse
//   mem_err_o    out  range error (only with RISCV_DMEM_RANGE_CHECK_EN)

module riscv_dmem_ctrl #(
    parameter int          DEPTH       = 1024,
    parameter int          WAIT_STATES = 2,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        mem_req_i,
    input  logic        mem_we_i,
    input  logic [3:0]  mem_be_i,
    input  logic [31:0] mem_addr_i,
    input  logic [31:0] mem_wd_i,
    output logic [31:0] mem_rd_o,
    output logic        mem_ready_o
`ifdef RISCV_DMEM_RANGE_CHECK_EN
    ,
    output logic        mem_err_o
`endif
);

    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic        capture;

    logic [3:0]  cnt;
    logic        cap_we;
    logic [3:0]  cap_be;
    logic [31:0] cap_addr;
    logic [31:0] cap_wd;
    logic [31:0] rd_q;

    logic [31:0] mem [DEPTH];

    logic [31:0] offset;
    logic [AW-1:0] idx;
    logic        oor;
    logic [31:0] rd_now;
    logic        unused_bits;

    // Offset from the window base; for addresses below BASE_ADDR this wraps
    // to a large value, so a single upper-bit test covers both range ends.
    assign offset = cap_addr - BASE_ADDR;
    assign idx    = offset[AW+1:2];

`ifdef RISCV_DMEM_RANGE_CHECK_EN
    assign oor         = |offset[31:AW+2];
    assign unused_bits = ^offset[1:0];
`else
    assign oor         = 1'b0;
    assign unused_bits = ^{offset[31:AW+2], offset[1:0]};
`endif

    assign rd_now = oor ? 32'h0 : mem[idx];

    always_comb begin
        state_nxt = state;
        capture   = 1'b0;
        case (state)
            S_IDLE: begin
                if (mem_req_i) begin
                    capture   = 1'b1;
                    state_nxt = (WAIT_STATES == 0) ? S_RESP : S_WAIT;
                end
            end
            S_WAIT: begin
                if (cnt <= 4'd1) begin
                    state_nxt = S_RESP;
                end
            end
            S_RESP: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state    <= S_IDLE;
            cnt      <= 4'd0;
            cap_we   <= 1'b0;
            cap_be   <= 4'd0;
            cap_addr <= 32'h0;
            cap_wd   <= 32'h0;
            rd_q     <= 32'h0;
        end else begin
            state <= state_nxt;
            if (capture) begin
                cap_we   <= mem_we_i;
                cap_be   <= mem_be_i;
                cap_addr <= mem_addr_i;
                cap_wd   <= mem_wd_i;
                cnt      <= 4'(WAIT_STATES);
            end else if (state == S_WAIT) begin
                cnt <= cnt - 4'd1;
            end
            // Remember the word just returned so mem_rd_o holds it after RESP.
            if (state == S_RESP && !cap_we) begin
                rd_q <= rd_now;
            end
        end
    end

    // Array is not reset; a reset landing on the RESP edge discards the write.
    always_ff @(posedge clk_i) begin
        if (!rst_i && state == S_RESP && cap_we && !oor) begin
            for (int i = 0; i < 4; i++) begin
                if (cap_be[i]) begin
                    mem[idx][8*i +: 8] <= cap_wd[8*i +: 8];
                end
            end
        end
    end

    assign mem_ready_o = (state == S_RESP);
    assign mem_rd_o    = (state == S_RESP && !cap_we) ? rd_now : rd_q;

`ifdef RISCV_DMEM_RANGE_CHECK_EN
    assign mem_err_o = (state == S_RESP) && oor;
`endif

endmodule

// File: tb/tb_riscv_dmem_ctrl.sv
// Testbench for riscv_dmem_ctrl: two instances (WAIT_STATES=2 and 0) checked
// against a word-array model with directed steps followed by random traffic.
// Honors RISCV_DMEM_RANGE_CHECK_EN the same way as the design.

module tb_riscv_dmem_ctrl;

    localparam int          DEPTH = 1024;
    localparam logic [31:0] BASE  = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        req   [2];
    logic        we    [2];
    logic [3:0]  be    [2];
    logic [31:0] addr  [2];
    logic [31:0] wd    [2];
    logic [31:0] rd    [2];
    logic        ready [2];
`ifdef RISCV_DMEM_RANGE_CHECK_EN
    logic        err   [2];
`endif

    int errors = 0;
    int checks = 0;
    int cycle  = 0;
    int rdy_cyc [2];

    logic [31:0] mdl     [2][DEPTH];
    logic [31:0] last_rd [2];

    always #5 clk = ~clk;
    always @(posedge clk) cycle++;

    riscv_dmem_ctrl #(.DEPTH(DEPTH), .WAIT_STATES(2), .BASE_ADDR(BASE)) u_ws2 (
        .clk_i(clk), .rst_i(rst), .mem_req_i(req[0]), .mem_we_i(we[0]),
        .mem_be_i(be[0]), .mem_addr_i(addr[0]), .mem_wd_i(wd[0]),
        .mem_rd_o(rd[0]), .mem_ready_o(ready[0])
`ifdef RISCV_DMEM_RANGE_CHECK_EN
        , .mem_err_o(err[0])
`endif
    );

    riscv_dmem_ctrl #(.DEPTH(DEPTH), .WAIT_STATES(0), .BASE_ADDR(BASE)) u_ws0 (
        .clk_i(clk), .rst_i(rst), .mem_req_i(req[1]), .mem_we_i(we[1]),
        .mem_be_i(be[1]), .mem_addr_i(addr[1]), .mem_wd_i(wd[1]),
        .mem_rd_o(rd[1]), .mem_ready_o(ready[1])
`ifdef RISCV_DMEM_RANGE_CHECK_EN
        , .mem_err_o(err[1])
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One complete access on instance s. Called just after a rising edge with
    // the DUT idle; returns just after the edge that ends RESP (DUT idle again).
    task automatic access(input int s, input bit w, input logic [3:0] b,
                          input logic [31:0] a, input logic [31:0] d, input bit hold);
        int          ws;
        int          i;
        bit          oor;
        logic [31:0] e;
        ws  = (s == 0) ? 2 : 0;
        i   = int'(((a - BASE) / 32'd4) % 32'(DEPTH));
        oor = 1'b0;
`ifdef RISCV_DMEM_RANGE_CHECK_EN
        oor = (a < BASE) || (a - BASE >= 32'(DEPTH * 4));
`endif
        req[s] = 1'b1; we[s] = w; be[s] = b; addr[s] = a; wd[s] = d;
        for (int k = 1; k <= ws + 1; k++) begin
            @(posedge clk); #1;
            check($sformatf("ready_dut%0d_k%0d", s, k), 32'(ready[s]), 32'(k == ws + 1));
        end
        rdy_cyc[s] = cycle;
        if (w) begin
            check($sformatf("rd_hold_on_write_dut%0d", s), rd[s], last_rd[s]);
            if (!oor) begin
                for (int l = 0; l < 4; l++)
                    if (b[l]) mdl[s][i][8*l +: 8] = d[8*l +: 8];
            end
        end else begin
            e = oor ? 32'h0 : mdl[s][i];
            check($sformatf("rd_data_dut%0d_a%h", s, a), rd[s], e);
            last_rd[s] = e;
        end
`ifdef RISCV_DMEM_RANGE_CHECK_EN
        check($sformatf("err_dut%0d", s), 32'(err[s]), 32'(oor));
`endif
        if (!hold) req[s] = 1'b0;
        @(posedge clk); #1;
        check($sformatf("no_consec_ready_dut%0d", s), 32'(ready[s]), 32'h0);
        if (!hold) check($sformatf("rd_after_resp_dut%0d", s), rd[s], last_rd[s]);
    endtask

    initial begin
        int          prev;
        logic [31:0] a;
        bit          h;

        rst = 1'b1;
        for (int s = 0; s < 2; s++) begin
            req[s] = 1'b0; we[s] = 1'b0; be[s] = 4'h0; addr[s] = 32'h0; wd[s] = 32'h0;
            last_rd[s] = 32'h0; rdy_cyc[s] = 0;
        end
        repeat (3) @(posedge clk);
        #1;
        for (int s = 0; s < 2; s++) begin
            check($sformatf("reset_ready_dut%0d", s), 32'(ready[s]), 32'h0);
            check($sformatf("reset_rd_dut%0d", s), rd[s], 32'h0);
`ifdef RISCV_DMEM_RANGE_CHECK_EN
            check($sformatf("reset_err_dut%0d", s), 32'(err[s]), 32'h0);
`endif
        end
        rst = 1'b0;

        // Give every word used below a known value.
        for (int s = 0; s < 2; s++)
            for (int i = 0; i < 32; i++)
                access(s, 1'b1, 4'hF, BASE + 32'(i * 4), $urandom, 1'b0);

        // Full-word write and read-back with WAIT_STATES=2 latency.
        access(0, 1'b1, 4'hF, BASE + 32'h10, 32'hDEADBEEF, 1'b0);
        access(0, 1'b0, 4'h0, BASE + 32'h10, 32'h0, 1'b0);
        check("deadbeef_read", rd[0], 32'hDEADBEEF);

        // Single byte lane write.
        access(0, 1'b1, 4'b0100, BASE + 32'h10, 32'h5A5A5A5A, 1'b0);
        access(0, 1'b0, 4'h0, BASE + 32'h13, 32'h0, 1'b0);
        check("byte_lane_read", rd[0], 32'hDE5ABEEF);

        // be = 0 is a no-op write that still completes.
        access(0, 1'b1, 4'b0000, BASE + 32'h10, 32'hFFFFFFFF, 1'b0);
        access(0, 1'b0, 4'h0, BASE + 32'h10, 32'h0, 1'b0);

        // Back-to-back write then read of the same word, request held.
        access(0, 1'b1, 4'hF, BASE + 32'h18, 32'hCAFEF00D, 1'b1);
        prev = rdy_cyc[0];
        access(0, 1'b0, 4'h0, BASE + 32'h18, 32'h0, 1'b0);
        check("raw_period_ws2", 32'(rdy_cyc[0] - prev), 32'd4);

        // WAIT_STATES=0 with request held: ready every second cycle.
        access(1, 1'b0, 4'h0, BASE + 32'h0, 32'h0, 1'b1);
        for (int n = 0; n < 6; n++) begin
            prev = rdy_cyc[1];
            access(1, 1'b0, 4'h0, BASE + 32'(n * 4 + 4), 32'h0, n != 5);
            check($sformatf("b2b_period_ws0_%0d", n), 32'(rdy_cyc[1] - prev), 32'd2);
        end

        // Reset during WAIT discards the pending write and its ready pulse.
        access(0, 1'b1, 4'hF, BASE + 32'h20, 32'h0, 1'b0);
        req[0] = 1'b1; we[0] = 1'b1; be[0] = 4'hF; addr[0] = BASE + 32'h20; wd[0] = 32'h1;
        @(posedge clk); #1;
        check("midrst_ready_wait", 32'(ready[0]), 32'h0);
        rst = 1'b1; req[0] = 1'b0;
        @(posedge clk); #1;
        check("midrst_ready_in_rst", 32'(ready[0]), 32'h0);
        check("midrst_rd_reset", rd[0], 32'h0);
        rst = 1'b0;
        last_rd[0] = 32'h0; last_rd[1] = 32'h0;
        repeat (4) begin
            @(posedge clk); #1;
            check("midrst_no_ready", 32'(ready[0]), 32'h0);
        end
        access(0, 1'b0, 4'h0, BASE + 32'h20, 32'h0, 1'b0);
        check("midrst_read_0x20", rd[0], 32'h0);

        // Address beyond DEPTH words: error with the range check, wrap without.
        access(0, 1'b0, 4'h0, BASE + 32'h1000, 32'h0, 1'b0);
`ifdef RISCV_DMEM_RANGE_CHECK_EN
        check("oor_read_zero", rd[0], 32'h0);
        access(0, 1'b1, 4'hF, BASE + 32'h1000, 32'h12345678, 1'b0);
        access(0, 1'b0, 4'h0, BASE + 32'h0, 32'h0, 1'b0);
`else
        check("wrap_read_word0", rd[0], mdl[0][0]);
        access(0, 1'b1, 4'hF, BASE + 32'h1004, 32'h12345678, 1'b0);
        access(0, 1'b0, 4'h0, BASE + 32'h4, 32'h0, 1'b0);
        check("wrap_write_word1", rd[0], 32'h12345678);
`endif

        // Random traffic over a small word window to force collisions.
        for (int s = 0; s < 2; s++) begin
            for (int n = 0; n < 40; n++) begin
                a = BASE + 32'($urandom_range(0, 31) * 4) + 32'($urandom_range(0, 3));
`ifndef RISCV_DMEM_RANGE_CHECK_EN
                a = a + (32'($urandom_range(0, 255)) << 12);
`endif
                h = (n != 39) && ($urandom_range(0, 1) == 1);
                access(s, 1'($urandom_range(0, 1)), 4'($urandom), a, $urandom, h);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/riscv_dmem_ctrl.md
# riscv_dmem_ctrl

Word-organised data memory with a wait-state sequencer, sitting directly downstream of the load/store unit on its `mem_*` bus. It captures a request, waits a configurable number of cycles, commits writes under byte enables or fetches read data, and signals completion with a single-cycle ready pulse that releases the LSU stall. Read data is the full 32-bit word; lane selection and sign extension stay in the LSU.

## Interface
Parameters:
- `DEPTH`, 1024: memory size in 32-bit words; power of two, ≥ 4.
- `WAIT_STATES`, 2: cycles spent in WAIT per access; 0..15.
- `BASE_ADDR`, 32'h0000_0000: byte address of word 0; aligned to DEPTH*4.

Ports (one clock; reset is synchronous and active-high):
- `clk_i` in 1: clock, all state on rising edge.
- `rst_i` in 1: synchronous active-high reset.
- `mem_req_i` in 1: access request; held with all qualifiers until `mem_ready_o`.
- `mem_we_i` in 1: 1 = write, 0 = read.
- `mem_be_i` in 4: byte-lane enables for writes; bit n covers bits 8n+7:8n.
- `mem_addr_i` in 32: byte address; bits 1:0 ignored.
- `mem_wd_i` in 32: write data, lanes already replicated by LSU.
- `mem_rd_o` out 32: read data, valid while `mem_ready_o` = 1.
- `mem_ready_o` out 1: one-cycle completion pulse.
- `mem_err_o` out 1: range error, present only with `RISCV_DMEM_RANGE_CHECK_EN`.

## Operation
- States: IDLE, WAIT, RESP.
- IDLE: `mem_req_i` = 1 → capture we, be, addr, wd into internal registers; load wait counter with WAIT_STATES; go WAIT (WAIT_STATES > 0) or RESP (WAIT_STATES = 0).
- WAIT: decrement counter each cycle; at counter = 1 go RESP. Inputs ignored; captured request is completed even if `mem_req_i` drops.
- RESP: `mem_ready_o` = 1 for exactly this cycle; go IDLE.
- Write: committed at the RESP clock edge, only lanes with be bit set; other lanes unchanged; be = 0 is a legal no-op write that still pulses ready.
- Read: word read from array for RESP cycle; `mem_rd_o` holds last read word afterwards; writes leave `mem_rd_o` unchanged.
- Word index = (captured addr − BASE_ADDR) >> 2, low log2(DEPTH) bits.
- IDLE is the only accepting state; a request present in the cycle after RESP is accepted immediately (back-to-back).

## Timing
- Reset values: state IDLE, counter 0, `mem_ready_o` 0, `mem_rd_o` 32'h0, `mem_err_o` 0. Array contents not reset.
- Latency: request accepted in cycle T → `mem_ready_o` in cycle T+WAIT_STATES+1.
- Throughput: one access per WAIT_STATES+2 cycles with request held continuously.
- `rst_i` mid-access (WAIT or RESP before edge): return to IDLE, pending write discarded, no ready pulse.
- Read-after-write to same word, back-to-back: read returns newly written data.
- `mem_ready_o` never asserted in two consecutive cycles.

## Configuration
- `RISCV_DMEM_RANGE_CHECK_EN` defined: `mem_err_o` exists; address outside [BASE_ADDR, BASE_ADDR+DEPTH*4) completes with normal latency, `mem_err_o` = 1 together with `mem_ready_o`, write suppressed, `mem_rd_o` = 32'h0 for that read.
- Not defined: no `mem_err_o` port; upper address bits ignored, access wraps modulo DEPTH.

## Test plan
- Reset then WAIT_STATES=2, write 32'hDEADBEEF be=4'b1111 to 0x10 at cycle 0 → ready at cycle 3; read 0x10 → ready 3 cycles after acceptance, `mem_rd_o` = 32'hDEADBEEF.
- Byte write be=4'b0100, wd=32'h5A5A5A5A to 0x10 → subsequent read returns 32'hDE5ABEEF.
- WAIT_STATES=0, back-to-back read requests held high → ready every 2nd cycle, never on consecutive cycles.
- Assert `rst_i` in WAIT during write of 32'h1 to 0x20 (previously 32'h0) → no ready pulse, read of 0x20 returns 32'h0.
- With macro, read 0x0000_1000 at DEPTH=1024, BASE 0 → ready with `mem_err_o` = 1, `mem_rd_o` = 0; without macro, same read returns word 0.
